// File: rtl/spi_mem_master_pkg.sv
// ----------------------------------------------------------------------------
// spi_mem_master_pkg
//   Definitions shared by the SPI memory initiator and the slave-side command
//   decoder: command codes, frame field widths, FSM state encoding and a
//   helper that assembles the 32-bit transmit frame.
// ----------------------------------------------------------------------------
package spi_mem_master_pkg;

    localparam int CMD_W   = 8;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;

    localparam logic [CMD_W-1:0] SPI_CMD_READ  = 8'h03;
    localparam logic [CMD_W-1:0] SPI_CMD_WRITE = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    // Reads put 0x00 in the data phase; the slave ignores it.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rw,
        input logic [CMD_W-1:0]  cmd_rd,
        input logic [CMD_W-1:0]  cmd_wr,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {(rw ? cmd_wr : cmd_rd), addr, (rw ? wdata : {DATA_W{1'b0}})};
    endfunction

endpackage

// File: rtl/spi_mem_master_clk_gen.sv
// ----------------------------------------------------------------------------
// spi_mem_master_clk_gen
//   CLK_DIV divider for the SPI initiator. While en_i is high the 8-bit
//   divider counts 0..CLK_DIV-1 and tick_o marks the terminal count. When
//   toggle_i is also high, sclk toggles on each tick and rise_o / fall_o
//   flag the clk edge on which sclk goes 0->1 / 1->0. en_i low clears the
//   divider and forces sclk low.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   en_i       run the divider
//   toggle_i   allow sclk to toggle at terminal count
//   sclk_o     registered SPI clock, idle low
//   tick_o     divider terminal count (combinational)
//   rise_o     sclk rises on the coming edge
//   fall_o     sclk falls on the coming edge
// ----------------------------------------------------------------------------
module spi_mem_master_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic toggle_i,
    output logic sclk_o,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_q, div_d;
    logic       sclk_q, sclk_d;

    always_comb begin
        tick_o = en_i && (div_q == DIV_LAST);
        rise_o = tick_o && toggle_i && !sclk_q;
        fall_o = tick_o && toggle_i && sclk_q;
        div_d  = 8'd0;
        sclk_d = 1'b0;
        if (en_i) begin
            div_d  = tick_o ? 8'd0 : div_q + 8'd1;
            sclk_d = (tick_o && toggle_i) ? !sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= 8'd0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_mem_master.sv
// ----------------------------------------------------------------------------
// spi_mem_master
//   SPI mode-0 initiator issuing single-byte memory transactions. Frame is
//   32 bits MSB-first: command (READ 0x03 / WRITE 0x02), 16-bit address,
//   8-bit data. rdata returns the last 8 bits sampled during the frame.
//   FSM: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE; done is 66*CLK_DIV clk
//   cycles after the start-accept edge.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start           request strobe, sampled only while idle
//   rw, addr, wdata request (1=write), latched with start
//   busy, done      transaction in flight / one-cycle end pulse
//   rdata           captured read byte, valid from done
//   sclk, cs_n,
//   mosi, miso      SPI pins (sclk/cs_n/mosi registered)
//   loopback        only with SPI_LOOPBACK_EN: sample mosi instead of miso
// Build option:
//   SPI_LOOPBACK_EN adds the loopback self-test input.
// ----------------------------------------------------------------------------
module spi_mem_master
    import spi_mem_master_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [7:0] CMD_READ  = SPI_CMD_READ,
    parameter logic [7:0] CMD_WRITE = SPI_CMD_WRITE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic        loopback
`endif
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_W - 1);

    spi_state_e         state_q, state_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               div_en, div_toggle, tick, rise, fall;
    logic               rx_bit;
    logic [FRAME_W-1:0] frame;

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = loopback ? mosi_q : miso;
`else
    assign rx_bit = miso;
`endif

    assign frame      = build_frame(rw, CMD_READ, CMD_WRITE, addr, wdata);
    assign div_en     = (state_q != ST_IDLE);
    assign div_toggle = (state_q == ST_SHIFT);

    spi_mem_master_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .en_i     (div_en),
        .toggle_i (div_toggle),
        .sclk_o   (sclk),
        .tick_o   (tick),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        bit_cnt_d = bit_cnt_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_d      = frame;
                    mosi_d    = frame[FRAME_W-1];
                    bit_cnt_d = 6'd0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (rise) rx_d = {rx_q[DATA_W-2:0], rx_bit};
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    // The 32nd falling edge leaves sclk low and ends shifting.
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
                        mosi_d = tx_q[FRAME_W-2];
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = rx_q;
                    mosi_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            bit_cnt_q <= 6'd0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            bit_cnt_q <= bit_cnt_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign cs_n  = cs_n_q;
    assign mosi  = mosi_q;

endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
SPI mode-0 initiator that issues single-byte memory transactions to the on-chip SPI command-decoding slave. Each frame is MSB-first, 32 bits: 8-bit command (READ 0x03 / WRITE 0x02), 16-bit address, then 8-bit data. Writes drive wdata in the data phase; reads drive 0x00 and capture MISO. Sits between the host-side request logic and the SPI pins.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255
CMD_READ, 8'b00000011, read command code
CMD_WRITE, 8'b00000010, write command code

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  request strobe; sampled only while busy=0
rw  input  1  1=write, 0=read; latched with start
addr  input  16  target address; latched with start
wdata  input  8  write data; latched with start
busy  output  1  high from the start-accept edge until done
done  output  1  one-cycle pulse at end of frame
rdata  output  8  last 8 bits sampled from MISO; valid from done
sclk  output  1  SPI clock, idle low
cs_n  output  1  chip select, active-low
mosi  output  1  serial data out
miso  input  1  serial data in

Behaviour:
- Reset (async): state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rdata=0x00, all counters 0. Reset mid-frame aborts at once: cs_n high, no done pulse.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE: start=1 at an edge loads tx shift {rw?CMD_WRITE:CMD_READ, addr, rw?wdata:8'h00}, sets cs_n=0, busy=1, mosi=tx[31], divider=0. Next state is SETUP. start while busy=1 is ignored; no queuing.
- SETUP: hold for CLK_DIV cycles with sclk=0, then go to SHIFT.
- SHIFT: divider counts 0..CLK_DIV-1. At terminal count, sclk toggles.
  - Rising edge (0->1): shift miso into the LSB of the 8-bit rx register.
  - Falling edge (1->0): increment bit_cnt. If bit_cnt reaches 32, go to HOLD with sclk low. Otherwise shift tx left and drive mosi with the new MSB.
  - Each bit lasts 2*CLK_DIV cycles.
- HOLD: CLK_DIV cycles with cs_n=0 and sclk=0. On expiry: cs_n=1, busy=0, done=1 for one cycle, rdata<=rx, mosi=0, go to IDLE.
- rdata is updated on both read and write frames. For a write it holds whatever the slave returned.
- Latency: done asserts exactly 66*CLK_DIV cycles after the start-accept edge. start may be re-asserted in the done cycle and is accepted on that same edge, because busy is already 0.
- bit_cnt is 6 bits and never wraps within a frame. The divider is 8 bits.
- sclk, cs_n and mosi are registered outputs (glitch-free).

Optional Feature:
SPI_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback=1, the rx sampling source is the internal mosi instead of miso. This is for self-test without a slave.
- Undefined: no loopback port; rx always samples miso.

Decomposition:
- Shared header spi_defs.vh holds:
  - command codes (0x03, 0x02)
  - frame lengths (CMD=8, ADDR=16, DATA=8, FRAME=32)
  - state encodings (IDLE, SETUP, SHIFT, HOLD)
  The slave-side command decoder includes the same header.
- One sub-module, spi_clk_gen: the CLK_DIV divider that produces sclk, rise_en and fall_en pulses, gated by an enable from the FSM.

Test Plan:
- Write, CLK_DIV=4, rw=1, addr=0x1234, wdata=0xA5: MOSI sampled on SCLK rising edges = 0x02,0x12,0x34,0xA5. Exactly 32 SCLK pulses, cs_n low throughout, done at cycle 264 after start.
- Read, rw=0, addr=0xBEEF, slave model drives 0x5C in the data phase: MOSI = 0x03,0xBE,0xEF,0x00; rdata=0x5C at done; busy falls with done.
- start pulsed every cycle for 600 cycles: exactly two frames complete. Back-to-back start accepted in the done cycle; starts during busy ignored; cs_n deasserts for at least 1 cycle between frames.
- rst asserted at bit 17 of a write: same cycle cs_n=1, sclk=0, mosi=0, busy=0, no done pulse. A new read after release completes normally.
- CLK_DIV=2 boundary: SCLK high and low each last 2 clk cycles; done at cycle 132; miso held constant 1 gives rdata=0xFF.
- SPI_LOOPBACK_EN defined, loopback=1, write wdata=0x3C with miso tied 0: rdata=0x3C.
